// File: rtl/imsic_csr_arbiter.sv
// Round-robin arbiter that shares one IMSIC CSR port among NR_REQ requesters.
// Each accepted request makes one IMSIC access cycle and returns one response pulse.
module imsic_csr_arbiter #(
    parameter int NR_REQ           = 4,
    parameter int DATA_W           = 32,
    parameter int VS_INTP_FILE_LEN = 1
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic [NR_REQ-1:0]                      i_req_valid,
    output logic [NR_REQ-1:0]                      o_req_ready,
    input  logic [2*NR_REQ-1:0]                    i_req_priv_lvl,
    input  logic [(VS_INTP_FILE_LEN+1)*NR_REQ-1:0] i_req_vgein,
    input  logic [DATA_W*NR_REQ-1:0]               i_req_addr,
    input  logic [DATA_W*NR_REQ-1:0]               i_req_data,
    input  logic [NR_REQ-1:0]                      i_req_we,
    input  logic [NR_REQ-1:0]                      i_req_claim,
    output logic [NR_REQ-1:0]                      o_rsp_valid,
    output logic [DATA_W-1:0]                      o_rsp_data,
    output logic [1:0]                             o_imsic_priv_lvl,
    output logic [VS_INTP_FILE_LEN:0]              o_imsic_vgein,
    output logic [DATA_W-1:0]                      o_imsic_addr,
    output logic [DATA_W-1:0]                      o_imsic_data,
    output logic                                   o_imsic_we,
    output logic                                   o_imsic_claim,
    input  logic [DATA_W-1:0]                      i_imsic_data,
    output logic                                   o_busy
);

    localparam int VG_W  = VS_INTP_FILE_LEN + 1;
    localparam int PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam logic [PTR_W:0]   NR_REQ_W   = (PTR_W+1)'(NR_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX_W = PTR_W'(NR_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [PTR_W-1:0]  r_gnt_idx;
    logic [PTR_W-1:0]  w_gnt_idx;
    logic [PTR_W-1:0]  w_rr_ptr_nxt;
    logic              w_gnt_found;
    logic              w_accept;
    logic [NR_REQ-1:0] w_gnt_oh;
    logic [NR_REQ-1:0] w_rsp_oh;

    logic [1:0]        r_priv;
    logic [VG_W-1:0]   r_vgein;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_we;
    logic              r_claim;
    logic [DATA_W-1:0] r_rsp_q;

    logic [1:0]        w_priv_arr  [NR_REQ];
    logic [VG_W-1:0]   w_vgein_arr [NR_REQ];
    logic [DATA_W-1:0] w_addr_arr  [NR_REQ];
    logic [DATA_W-1:0] w_data_arr  [NR_REQ];

    for (genvar g = 0; g < NR_REQ; g++) begin : g_unpack
        assign w_priv_arr[g]  = i_req_priv_lvl[2*g +: 2];
        assign w_vgein_arr[g] = i_req_vgein[VG_W*g +: VG_W];
        assign w_addr_arr[g]  = i_req_addr[DATA_W*g +: DATA_W];
        assign w_data_arr[g]  = i_req_data[DATA_W*g +: DATA_W];
    end

    // First valid requester at or above r_rr_ptr, wrapping past NR_REQ-1.
    always_comb begin : grant_search
        logic [PTR_W:0] w_sum;
        w_sum       = '0;
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
            if (w_sum >= NR_REQ_W) begin
                w_sum = w_sum - NR_REQ_W;
            end
            if (!w_gnt_found && i_req_valid[w_sum[PTR_W-1:0]]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_sum[PTR_W-1:0];
            end
        end
    end

    assign w_rr_ptr_nxt = (w_gnt_idx == LAST_IDX_W) ? '0 : w_gnt_idx + PTR_W'(1);

    always_comb begin
        w_gnt_oh = '0;
        w_rsp_oh = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            w_gnt_oh[i] = (w_gnt_idx == PTR_W'(i));
            w_rsp_oh[i] = (r_gnt_idx == PTR_W'(i));
        end
    end

    // Handshake: a requester holds i_req_valid and its fields stable until it sees
    // its o_req_ready bit; fields are sampled only in that cycle. o_rsp_valid is a
    // single-cycle strobe two cycles later, with o_rsp_data valid alongside it.
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        o_req_ready   = '0;
        o_rsp_valid   = '0;
        o_imsic_we    = 1'b0;
        o_imsic_claim = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_found) begin
                    w_state_nxt = ISSUE;
                    w_accept    = !i_rst;
                    o_req_ready = i_rst ? '0 : w_gnt_oh;
                end
            end
            ISSUE: begin
                w_state_nxt   = RESP;
                o_imsic_we    = r_we;
                o_imsic_claim = r_claim;
            end
            RESP: begin
                w_state_nxt = IDLE;
                o_rsp_valid = i_rst ? '0 : w_rsp_oh;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_rr_ptr  <= '0;
            r_gnt_idx <= '0;
            r_priv    <= '0;
            r_vgein   <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_we      <= 1'b0;
            r_claim   <= 1'b0;
            r_rsp_q   <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Read data is taken before the IMSIC applies the write/claim.
            if (r_state == ISSUE) begin
                r_rsp_q <= i_imsic_data;
            end
            if (w_accept) begin
                r_rr_ptr  <= w_rr_ptr_nxt;
                r_gnt_idx <= w_gnt_idx;
                r_priv    <= w_priv_arr[w_gnt_idx];
                r_vgein   <= w_vgein_arr[w_gnt_idx];
                r_addr    <= w_addr_arr[w_gnt_idx];
                r_data    <= w_data_arr[w_gnt_idx];
                r_we      <= i_req_we[w_gnt_idx];
                r_claim   <= i_req_claim[w_gnt_idx];
            end
        end
    end

    assign o_imsic_priv_lvl = r_priv;
    assign o_imsic_vgein    = r_vgein;
    assign o_imsic_addr     = r_addr;
    assign o_imsic_data     = r_data;
    assign o_rsp_data       = r_rsp_q;
    assign o_busy           = (r_state != IDLE);

`ifndef SYNTHESIS
    a_ready_onehot0 : assert property (@(posedge i_clk) disable iff (i_rst)
        $onehot0(o_req_ready));
    a_rsp_onehot0 : assert property (@(posedge i_clk) disable iff (i_rst)
        $onehot0(o_rsp_valid));
    a_ready_rsp_excl : assert property (@(posedge i_clk) disable iff (i_rst)
        !((|o_req_ready) && (|o_rsp_valid)));
`endif

endmodule
